// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Fetch-side lookup, execute-side training and perf-counter
//                signals of the branch predictor, bundled as one interface.
//                The predictor attaches through the slave modport; the
//                fetch/execute logic (or a testbench) uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int PC_WIDTH = 32,
    parameter int XLEN     = 32,
    parameter int IDX_W    = 6
);
    // Fetch-side lookup (mini-decode hints)
    logic [PC_WIDTH-1:0] F_PC_i;
    logic                F_train_vaild_i;
    logic                mini_op_jal_i;
    logic [XLEN-1:0]     mini_branch_jmp_i;
    logic [XLEN-1:0]     mini_jal_jmp_i;
    logic                F_pred_taken_o;
    logic [PC_WIDTH-1:0] F_next_pc_o;
    logic [IDX_W-1:0]    F_pred_index_o;

    // Execute-side training
    logic                E_train_valid_i;
    logic [IDX_W-1:0]    E_train_index_i;
    logic                E_train_taken_i;
    logic                E_mispredict_i;

    // Performance counters
    logic [31:0]         branch_cnt_o;
    logic [31:0]         mispred_cnt_o;

    // Predictor side
    modport slave (
        input  F_PC_i,
        input  F_train_vaild_i,
        input  mini_op_jal_i,
        input  mini_branch_jmp_i,
        input  mini_jal_jmp_i,
        output F_pred_taken_o,
        output F_next_pc_o,
        output F_pred_index_o,
        input  E_train_valid_i,
        input  E_train_index_i,
        input  E_train_taken_i,
        input  E_mispredict_i,
        output branch_cnt_o,
        output mispred_cnt_o
    );

    // Fetch / execute pipeline side
    modport master (
        output F_PC_i,
        output F_train_vaild_i,
        output mini_op_jal_i,
        output mini_branch_jmp_i,
        output mini_jal_jmp_i,
        input  F_pred_taken_o,
        input  F_next_pc_o,
        input  F_pred_index_o,
        output E_train_valid_i,
        output E_train_index_i,
        output E_train_taken_i,
        output E_mispredict_i,
        input  branch_cnt_o,
        input  mispred_cnt_o
    );
endinterface : branch_predictor_if
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-stage direction predictor built from a table of 2-bit
//                saturating counters. Lookup is purely combinational; training
//                from the execute stage takes effect on the next clock edge
//                (lookups in the training cycle see the old value).
//                Keeps resolved-branch and mispredict performance counters.
//                Optional feature macro: BP_GSHARE_EN - adds a non-speculative
//                global history register XORed into the lookup index.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int BHT_DEPTH = 64,   // power of two, >= 4
    parameter int GHR_WIDTH = 6,    // 1 <= GHR_WIDTH <= log2(BHT_DEPTH)
    parameter int PC_WIDTH  = 32,
    parameter int XLEN      = 32    // must be >= PC_WIDTH
) (
    input  wire logic           clk_i,
    input  wire logic           rst_n_i,
    branch_predictor_if.slave   bp_if
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST
    localparam logic [1:0] c_ctr_init = 2'b01;
    localparam logic [1:0] c_ctr_max  = 2'b11;
    localparam logic [1:0] c_ctr_min  = 2'b00;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [1:0]          bht_q [BHT_DEPTH];
    logic [1:0]          bht_wr_d;
    logic [31:0]         branch_cnt_q;
    logic [31:0]         branch_cnt_d;
    logic [31:0]         mispred_cnt_q;
    logic [31:0]         mispred_cnt_d;

    // ------------------------------------------------------------------
    // Lookup index
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]    w_base_idx;
    logic [IDX_W-1:0]    w_lookup_idx;

    // Word-aligned PC bits select the entry; higher bits alias freely.
    assign w_base_idx = bp_if.F_PC_i[IDX_W+1:2];

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_q;
    logic [GHR_WIDTH-1:0] ghr_d;
    logic [GHR_WIDTH-1:0] w_ghr_shift;
    logic [IDX_W-1:0]     w_ghr_ext;

    // History shift: newest outcome enters at bit 0.
    generate
        if (GHR_WIDTH == 1) begin : g_ghr_single
            assign w_ghr_shift = bp_if.E_train_taken_i;
        end else begin : g_ghr_multi
            assign w_ghr_shift = {ghr_q[GHR_WIDTH-2:0], bp_if.E_train_taken_i};
        end
    endgenerate

    // History advances only on resolved branches (non-speculative).
    always_comb begin
        ghr_d = ghr_q;
        if (bp_if.E_train_valid_i) begin
            ghr_d = w_ghr_shift;
        end
    end

    // Global history register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign w_ghr_ext    = IDX_W'(ghr_q);
    assign w_lookup_idx = w_base_idx ^ w_ghr_ext;
`else
    assign w_lookup_idx = w_base_idx;
`endif

    // ------------------------------------------------------------------
    // Prediction (combinational, reads the pre-update table contents)
    // ------------------------------------------------------------------
    logic [1:0]          w_lookup_ctr;
    logic                w_pred_taken;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_branch_tgt;
    logic [PC_WIDTH-1:0] w_jal_tgt;
    logic [PC_WIDTH-1:0] w_next_pc;

    assign w_lookup_ctr = bht_q[w_lookup_idx];
    assign w_pred_taken = bp_if.F_train_vaild_i & w_lookup_ctr[1];
    assign w_pc_plus4   = bp_if.F_PC_i + PC_WIDTH'(4);
    assign w_branch_tgt = bp_if.mini_branch_jmp_i[PC_WIDTH-1:0];
    assign w_jal_tgt    = bp_if.mini_jal_jmp_i[PC_WIDTH-1:0];

    // Next fetch PC: jal beats a predicted-taken branch, which beats PC+4.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (bp_if.mini_op_jal_i) begin
            w_next_pc = w_jal_tgt;
        end else if (w_pred_taken) begin
            w_next_pc = w_branch_tgt;
        end
    end

    assign bp_if.F_pred_taken_o = w_pred_taken;
    assign bp_if.F_next_pc_o    = w_next_pc;
    assign bp_if.F_pred_index_o = w_lookup_idx;

    // ------------------------------------------------------------------
    // Training
    // ------------------------------------------------------------------
    logic [1:0]          w_train_ctr;

    // The index travels with the branch from fetch; it is never recomputed
    // here, so history changes since fetch do not redirect the update.
    assign w_train_ctr = bht_q[bp_if.E_train_index_i];

    // Saturating increment on taken, saturating decrement on not-taken.
    always_comb begin
        bht_wr_d = w_train_ctr;
        if (bp_if.E_train_taken_i) begin
            if (w_train_ctr != c_ctr_max) begin
                bht_wr_d = w_train_ctr + 2'd1;
            end
        end else begin
            if (w_train_ctr != c_ctr_min) begin
                bht_wr_d = w_train_ctr - 2'd1;
            end
        end
    end

    // Counter table: every entry returns to weakly-not-taken on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= c_ctr_init;
            end
        end else if (bp_if.E_train_valid_i) begin
            bht_q[bp_if.E_train_index_i] <= bht_wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // ------------------------------------------------------------------
    // Next-state of both perf counters.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bp_if.E_train_valid_i) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (bp_if.E_mispredict_i) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    // Perf counter registers, updated on the same edge as the table.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bp_if.branch_cnt_o  = branch_cnt_q;
    assign bp_if.mispred_cnt_o = mispred_cnt_q;

endmodule : branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor that consumes the fetch-side mini-decode hints (branch flag, jal flag, precomputed targets) and returns a taken/not-taken prediction and the next fetch PC. It is trained from the execute stage with resolved branch outcomes. Storage is a table of 2-bit saturating counters, optionally indexed gshare-style through a global history register. It also keeps retired-branch and mispredict performance counters.

## Interface
- `BHT_DEPTH`, 64, number of counter entries; must be a power of 2, at least 4. `IDX_W = log2(BHT_DEPTH)`.
- `GHR_WIDTH`, 6, global history length; must satisfy 1 ≤ `GHR_WIDTH` ≤ `IDX_W`. Only used with `BP_GSHARE_EN`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `F_PC_i`  in  `PC_WIDTH`  current fetch PC.
- `F_train_vaild_i`  in  1  instruction at `F_PC_i` is a conditional branch (from mini-decode).
- `mini_op_jal_i`  in  1  instruction at `F_PC_i` is jal.
- `mini_branch_jmp_i`  in  `XLEN`  branch target (imm + PC).
- `mini_jal_jmp_i`  in  `XLEN`  jal target.
- `F_pred_taken_o`  out  1  prediction for a branch at `F_PC_i`.
- `F_next_pc_o`  out  `PC_WIDTH`  predicted next fetch PC.
- `F_pred_index_o`  out  `IDX_W`  table index used for this prediction; pipelined down to E for training.
- `E_train_valid_i`  in  1  a conditional branch resolved in E this cycle.
- `E_train_index_i`  in  `IDX_W`  index carried from F for that branch.
- `E_train_taken_i`  in  1  resolved direction.
- `E_mispredict_i`  in  1  resolved direction differed from the prediction; only meaningful with `E_train_valid_i`.
- `branch_cnt_o`  out  32  resolved branches since reset.
- `mispred_cnt_o`  out  32  mispredicted branches since reset.

## Operation
- Table: `BHT_DEPTH` × 2-bit counters. Encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Base index: `F_PC_i[IDX_W+1:2]`.
- `F_pred_taken_o` = `F_train_vaild_i` & counter[index][1]. The output is 0 when the instruction is not a branch.
- `F_next_pc_o` priority:
  - `mini_op_jal_i` → `mini_jal_jmp_i`.
  - else `F_pred_taken_o` → `mini_branch_jmp_i`.
  - else `F_PC_i + 4`, truncated to `PC_WIDTH` and wrapping at the top of the address space.
- `F_pred_index_o` is always driven with the computed index, even for non-branches.
- Training happens when `E_train_valid_i` is 1:
  - Taken: counter[`E_train_index_i`] increments, saturating at 11.
  - Not taken: the counter decrements, saturating at 00.
- Perf counters:
  - `branch_cnt_o` increments on every `E_train_valid_i`.
  - `mispred_cnt_o` increments on `E_train_valid_i & E_mispredict_i`.
  - Both wrap modulo 2^32.
- Aliasing is permitted. PCs with equal index bits share one counter.
- Reset (asserted at any time, including mid-training): all counters → 01, GHR → 0, both perf counters → 0, taking effect immediately and asynchronously. A training request in the reset cycle is discarded.

## Timing
- Prediction path is purely combinational: `F_PC_i`/hints → `F_pred_taken_o`, `F_next_pc_o`, `F_pred_index_o` in the same cycle.
- Training latency is 1 cycle. An update from cycle N is visible to a lookup in cycle N+1.
- Simultaneous lookup and training of the same entry in one cycle: the lookup sees the pre-update value (read-before-write).
- Perf counters and the GHR update on the same edge as the table.
- Outputs after reset:
  - `F_pred_taken_o` = 0 for every PC (all counters 01).
  - `F_next_pc_o` = `F_PC_i+4`, or the jal target when `mini_op_jal_i` is 1.
  - `branch_cnt_o` = `mispred_cnt_o` = 0.

## Configuration
- `BP_GSHARE_EN` defined:
  - Adds a `GHR_WIDTH`-bit global history register, updated on each `E_train_valid_i` as {ghr[GHR_WIDTH-2:0], `E_train_taken_i`} (non-speculative).
  - Index = base index XOR zero-extended GHR.
  - Training uses `E_train_index_i` as carried from F, never recomputed.
- Undefined: no GHR register; index = base index.

## Test plan
- Reset, then `F_PC_i`=0x80000010, `F_train_vaild_i`=1, `mini_branch_jmp_i`=0x80000020 → `F_pred_taken_o`=0, `F_next_pc_o`=0x80000014, `F_pred_index_o`=4.
- Train index 4 taken on two consecutive cycles (counter 01→10→11), then repeat the lookup → `F_pred_taken_o`=1, `F_next_pc_o`=0x80000020, `branch_cnt_o`=2. Train taken once more → the counter stays at 11. One not-taken train → still predicts taken.
- `mini_op_jal_i`=1 with `mini_jal_jmp_i`=0x80000400 and counter[4]=00 → `F_next_pc_o`=0x80000400, `F_pred_taken_o`=0.
- Same cycle: lookup PC 0x80000110 (aliases index 4, counter=01) and train index 4 taken with `E_mispredict_i`=1 → that cycle predicts not-taken; the next cycle predicts taken; `mispred_cnt_o`=1.
- Assert `rst_n_i` low mid-cycle after training → counters, `branch_cnt_o` and `mispred_cnt_o` read 0/01 before the next clock edge.
- With `BP_GSHARE_EN`, `GHR_WIDTH`=6: three taken trainings → GHR=000111. Lookup PC 0x80000010 → `F_pred_index_o`=3.
